// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of apb_master, seen from the master side.
// The master modport is the requester; the slave modport is whatever drives commands and PREADY/PRDATA.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_write;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [DATA_W-1:0] i_cmd_wdata;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;
    logic              o_busy;
    logic              o_psel;
    logic              o_penable;
    logic              o_pwrite;
    logic [ADDR_W-1:0] o_paddr;
    logic [DATA_W-1:0] o_pwdata;
    logic [DATA_W-1:0] i_prdata;
    logic              i_pready;

    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready, i_prdata, i_pready,
        output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy,
               o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready, i_prdata, i_pready,
        input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_busy,
               o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
    );
endinterface

// File: rtl/apb_master.sv
// APB requester: queues read/write commands in a FIFO and runs each as a SETUP/ACCESS transfer.
// Define APB_MST_TIMEOUT_EN to abort ACCESS phases that stall longer than TIMEOUT_CYC cycles.
module apb_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input logic          i_pclk,
    input logic          i_preset,
    apb_master_if.master bus
);
    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_fifoWrite [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifoAddr  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifoWdata [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W:0]    r_count;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rspValid;
    logic              r_rspErr;
    logic [DATA_W-1:0] r_rspRdata;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic              w_psel;
    logic              w_penable;
    logic              w_timeoutHit;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.i_cmd_valid && !w_full;
    assign w_pop   = w_done || w_abort;

`ifdef APB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_toCnt;

    assign w_timeoutHit = (r_toCnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge i_pclk) begin
        if (i_preset || r_state == SETUP) begin
            r_toCnt <= '0;
        end else if (r_state == ACCESS && !bus.i_pready && !w_timeoutHit) begin
            r_toCnt <= r_toCnt + CNT_W'(1);
        end
    end
`else
    assign w_timeoutHit = 1'b0;
`endif

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A new transfer may only start if its response will have somewhere to go.
                if (!w_empty && (!r_rspValid || bus.i_rsp_ready)) begin
                    w_start     = 1'b1;
                    w_nextState = SETUP;
                end
            end
            SETUP: begin
                w_psel      = 1'b1;
                w_nextState = ACCESS;
            end
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.i_pready) begin
                    w_done      = 1'b1;
                    w_nextState = IDLE;
                end else if (w_timeoutHit) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (w_push) begin
            r_fifoWrite[r_wrPtr] <= bus.i_cmd_write;
            r_fifoAddr[r_wrPtr]  <= bus.i_cmd_addr;
            r_fifoWdata[r_wrPtr] <= bus.i_cmd_wdata;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    // A completing transfer always lands in an empty response slot, so it may override the consume.
    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            if (w_start) begin
                r_pwrite <= r_fifoWrite[r_rdPtr];
                r_paddr  <= r_fifoAddr[r_rdPtr];
                r_pwdata <= r_fifoWdata[r_rdPtr];
            end
            if (w_done) begin
                r_rspValid <= 1'b1;
                r_rspErr   <= 1'b0;
                r_rspRdata <= r_pwrite ? '0 : bus.i_prdata;
            end else if (w_abort) begin
                r_rspValid <= 1'b1;
                r_rspErr   <= 1'b1;
                r_rspRdata <= '0;
            end else if (bus.i_rsp_ready) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    assign bus.o_cmd_ready = !w_full;
    assign bus.o_busy      = !w_empty || (r_state != IDLE);
    assign bus.o_psel      = w_psel;
    assign bus.o_penable   = w_penable;
    assign bus.o_pwrite    = r_pwrite;
    assign bus.o_paddr     = r_paddr;
    assign bus.o_pwdata    = r_pwdata;
    assign bus.o_rsp_valid = r_rspValid;
    assign bus.o_rsp_err   = r_rspErr;
    assign bus.o_rsp_rdata = r_rspRdata;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed timing scenarios plus random traffic, checked against a
// command-level model (a word memory and expected transfer/response queues in push order).
module tb_apb_master;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 8;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } apb_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk    = 1'b0;
    logic        preset = 1'b1;
    apb_t        apbQ[$];
    rsp_t        refQ[$];
    logic [31:0] refMem   [16];
    logic [31:0] slaveMem [16];
    int          nCompared   = 0;
    int          nMismatched = 0;
    int          nPushed     = 0;

    always #5 clk = ~clk;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_pclk(clk),
        .i_preset(preset),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        bus.i_cmd_valid = valid;
        bus.i_cmd_write = write;
        bus.i_cmd_addr  = addr;
        bus.i_cmd_wdata = wdata;
    endtask

    task automatic pushCmd(input string tag, input logic write, input logic [31:0] addr,
                           input logic [31:0] wdata);
        int   start;
        logic accepted;
        start    = nPushed;
        accepted = 1'b0;
        applyStimulus(1'b1, write, addr, wdata);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (nPushed != start) begin
                accepted = 1'b1;
                break;
            end
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput(tag, accepted, 1);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.o_busy && !bus.o_rsp_valid) break;
            tick();
        end
        checkOutput(tag, (!bus.o_busy && !bus.o_rsp_valid), 1);
    endtask

    // Model side: commands become expected transfers/responses at acceptance; the APB slave
    // serves PRDATA from its own memory and commits writes when a transfer completes.
    always @(negedge clk) begin : monitor
        apb_t a;
        rsp_t r;
        if (!preset) begin
            if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                nPushed++;
                apbQ.push_back('{bus.i_cmd_addr, bus.i_cmd_write, bus.i_cmd_wdata});
                if (bus.i_cmd_write) begin
                    refMem[bus.i_cmd_addr[5:2]] = bus.i_cmd_wdata;
                    refQ.push_back('{32'd0, 1'b0});
                end else begin
                    refQ.push_back('{refMem[bus.i_cmd_addr[5:2]], 1'b0});
                end
            end
            if (bus.o_psel && !bus.o_penable) begin
                if (apbQ.size() == 0) begin
                    checkOutput("setupUnexpected", bus.o_psel, 0);
                end else begin
                    a = apbQ.pop_front();
                    checkOutput("setupAddr", bus.o_paddr, a.addr);
                    checkOutput("setupWrite", bus.o_pwrite, a.write);
                    if (a.write) checkOutput("setupWdata", bus.o_pwdata, a.wdata);
                end
            end
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                if (refQ.size() == 0) begin
                    checkOutput("rspUnexpected", bus.o_rsp_valid, 0);
                end else begin
                    r = refQ.pop_front();
                    checkOutput("rspRdata", bus.o_rsp_rdata, r.rdata);
                    checkOutput("rspErr", bus.o_rsp_err, r.err);
                end
            end
            if (bus.o_psel && bus.o_penable && bus.i_pready && bus.o_pwrite) begin
                slaveMem[bus.o_paddr[5:2]] = bus.o_pwdata;
            end
        end
        bus.i_prdata = slaveMem[bus.o_paddr[5:2]];
    end

    initial begin
        int   accessCycles;
        logic addrStable;
        logic sawSetup;
        logic sawRsp;
        int   lowRun;
        int   pselCycles;

        for (int i = 0; i < 16; i++) begin
            refMem[i]   = 32'h1000 + 32'(i);
            slaveMem[i] = 32'h1000 + 32'(i);
        end
        refMem[2]   = 32'd24;
        slaveMem[2] = 32'd24;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        bus.i_rsp_ready = 1'b1;
        bus.i_pready    = 1'b1;

        // Reset held two cycles
        preset = 1'b1;
        repeat (2) tick();
        checkOutput("rstPselPenPwrite", {bus.o_psel, bus.o_penable, bus.o_pwrite}, 0);
        checkOutput("rstPaddr", bus.o_paddr, 0);
        checkOutput("rstPwdata", bus.o_pwdata, 0);
        checkOutput("rstRspValidErr", {bus.o_rsp_valid, bus.o_rsp_err}, 0);
        checkOutput("rstRspRdata", bus.o_rsp_rdata, 0);
        checkOutput("rstBusy", bus.o_busy, 0);
        checkOutput("rstCmdReady", bus.o_cmd_ready, 1);
        preset = 1'b0;

        // Single write: exact cycle timing
        pushCmd("t2_push", 1'b1, 32'd4, 32'd500);
        checkOutput("t2_idleAfterPush", {bus.o_psel, bus.o_busy}, 2'b01);
        tick();
        checkOutput("t2_setupPselPen", {bus.o_psel, bus.o_penable, bus.o_pwrite}, 3'b101);
        checkOutput("t2_setupPaddr", bus.o_paddr, 4);
        checkOutput("t2_setupPwdata", bus.o_pwdata, 500);
        tick();
        checkOutput("t2_accessPselPen", {bus.o_psel, bus.o_penable}, 2'b11);
        tick();
        checkOutput("t2_rspValidErr", {bus.o_rsp_valid, bus.o_rsp_err, bus.o_psel}, 3'b100);
        checkOutput("t2_rspRdata", bus.o_rsp_rdata, 0);

        // Read with three wait states
        bus.i_pready = 1'b0;
        pushCmd("t3_push", 1'b0, 32'd8, 32'd0);
        accessCycles = 0;
        addrStable   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.o_rsp_valid) break;
            if (bus.o_penable) begin
                accessCycles++;
                if (bus.o_paddr != 32'd8) addrStable = 1'b0;
            end
            bus.i_pready = (accessCycles >= 4);
        end
        checkOutput("t3_rspSeen", bus.o_rsp_valid, 1);
        checkOutput("t3_penableCycles", accessCycles, 4);
        checkOutput("t3_paddrStable", addrStable, 1);
        checkOutput("t3_rdata", bus.o_rsp_rdata, 24);

        // Stalled bus fills the FIFO; transfers must follow push order
        bus.i_pready = 1'b0;
        pushCmd("t4_push0", 1'b1, 32'd0, 32'hA0);
        pushCmd("t4_push1", 1'b1, 32'd4, 32'hA1);
        pushCmd("t4_push2", 1'b1, 32'd8, 32'hA2);
        pushCmd("t4_push3", 1'b1, 32'd16, 32'hA3);
        checkOutput("t4_fullAfter4", bus.o_cmd_ready, 0);
        applyStimulus(1'b1, 1'b1, 32'd56, 32'hA4);
        tick();
        checkOutput("t4_stillFull", bus.o_cmd_ready, 0);
        bus.i_pready = 1'b1;
        pushCmd("t4_push4", 1'b1, 32'd56, 32'hA4);
        waitIdle("t4_drain", 60);

        // Held response blocks the next SETUP
        bus.i_rsp_ready = 1'b0;
        pushCmd("t5_push0", 1'b0, 32'd8, 32'd0);
        pushCmd("t5_push1", 1'b0, 32'd12, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (bus.o_rsp_valid) break;
            tick();
        end
        sawSetup = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.o_psel) sawSetup = 1'b1;
        end
        checkOutput("t5_noSetupWhileHeld", sawSetup, 0);
        checkOutput("t5_rspHeld", bus.o_rsp_valid, 1);
        bus.i_rsp_ready = 1'b1;
        tick();
        checkOutput("t5_setupAfterRelease", {bus.o_psel, bus.o_penable, bus.o_rsp_valid}, 3'b100);
        waitIdle("t5_drain", 30);

        // Random traffic against the model
        lowRun = 0;
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 15)) << 2, $urandom);
            if (lowRun >= 3) bus.i_pready = 1'b1;
            else bus.i_pready = ($urandom_range(0, 3) != 0);
            lowRun = bus.i_pready ? 0 : lowRun + 1;
            bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        bus.i_pready    = 1'b1;
        bus.i_rsp_ready = 1'b1;
        waitIdle("rnd_drain", 100);
        checkOutput("rnd_rspQueueEmpty", refQ.size(), 0);
        checkOutput("rnd_apbQueueEmpty", apbQ.size(), 0);

        // Stuck slave: abort with error, or wait forever without the timeout feature
        bus.i_pready = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
        pushCmd("t6_push", 1'b0, 32'd12, 32'd0);
        if (refQ.size() > 0) refQ[refQ.size() - 1] = '{32'd0, 1'b1};
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.o_rsp_valid) break;
        end
        checkOutput("t6_errRsp", {bus.o_rsp_valid, bus.o_rsp_err}, 2'b11);
        checkOutput("t6_rdataZero", bus.o_rsp_rdata, 0);
        checkOutput("t6_pselDropped", {bus.o_psel, bus.o_penable}, 0);
        pushCmd("t7_push", 1'b0, 32'd16, 32'd0);
`else
        pushCmd("t6_push", 1'b0, 32'd12, 32'd0);
        pselCycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_psel) pselCycles++;
        end
        checkOutput("t6_pselStaysHigh", pselCycles, 20);
        checkOutput("t6_noRsp", bus.o_rsp_valid, 0);
`endif

        // Reset during ACCESS: bus drops, FIFO flushed, aborted command never responds
        for (int i = 0; i < 10; i++) begin
            if (bus.o_penable) break;
            tick();
        end
        checkOutput("t7_inAccess", bus.o_penable, 1);
        preset = 1'b1;
        tick();
        checkOutput("t7_rstPselPen", {bus.o_psel, bus.o_penable}, 0);
        checkOutput("t7_rstBusyReady", {bus.o_busy, bus.o_cmd_ready}, 2'b01);
        checkOutput("t7_rstRspValid", bus.o_rsp_valid, 0);
        preset = 1'b0;
        apbQ.delete();
        refQ.delete();
        bus.i_pready    = 1'b1;
        bus.i_rsp_ready = 1'b1;
        sawRsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.o_rsp_valid || bus.o_psel) sawRsp = 1'b1;
        end
        checkOutput("t7_noRspAfterReset", sawRsp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
